// File: rtl/msb_pkg.sv
// Shared types and helpers for the multi-stream buffer: stream/address types,
// the fixed BRAM read latency and the {sid,ptr} address packer.
package msb_pkg;

   localparam int BRAM_LATENCY    = 2;
   localparam int DEF_NUM_STREAMS = 4;
   localparam int DEF_RAM_DEPTH   = 512;

   typedef logic [$clog2(DEF_NUM_STREAMS)-1:0] sid_t;
   typedef logic [$clog2(DEF_RAM_DEPTH)-1:0]   bram_addr_t;

   // Stream segment select sits above the per-stream pointer.
   function automatic int unsigned pack_addr(input int unsigned sid,
                                             input int unsigned ptr,
                                             input int unsigned ptr_width);
      return (sid << ptr_width) | ptr;
   endfunction

endpackage

// File: rtl/bram_stream_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at the
// priority pointer, which moves just past the winner on every grant.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk2x,
   input  logic          reset,
   input  logic [N-1:0]  req_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] cand;
   logic          found;

   // N is a power of two, so pointer arithmetic wraps naturally.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = ptr_q + IW'(i);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            ptr_d       = cand + IW'(1);
         end
      end
   end

   always_ff @(posedge clk2x) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/bram_stream_sched.sv
// Per-stream circular queues in one shared BRAM: 1 write + 1 round-robin read per cycle,
// read data returns BRAM_LATENCY cycles after grant; writers see o_wr_r, no egress backpressure.
module bram_stream_sched
   import msb_pkg::*;
#(
   parameter int NUM_STREAMS = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int RAM_DEPTH   = 512,
   parameter int ADDR_WIDTH  = $clog2(RAM_DEPTH),
   parameter int SID_WIDTH   = $clog2(NUM_STREAMS),
   parameter int SEG_DEPTH   = RAM_DEPTH / NUM_STREAMS,
   parameter int PTR_WIDTH   = $clog2(SEG_DEPTH)
) (
   input  logic                   clk2x,
   input  logic                   reset,
   input  logic                   i_wr_v,
   input  logic [SID_WIDTH-1:0]   i_wr_sid,
   input  logic [DATA_WIDTH-1:0]  i_wr_d,
   output logic                   o_wr_r,
   input  logic [NUM_STREAMS-1:0] i_rd_req,
   output logic [NUM_STREAMS-1:0] o_rd_gnt,
   output logic                   o_rd_v,
   output logic [SID_WIDTH-1:0]   o_rd_sid,
   output logic [DATA_WIDTH-1:0]  o_rd_d,
   output logic [NUM_STREAMS-1:0] o_empty,
   output logic [NUM_STREAMS-1:0] o_full,
   output logic                   o_bram_we,
   output logic [ADDR_WIDTH-1:0]  o_bram_wa,
   output logic [DATA_WIDTH-1:0]  o_bram_wd,
   output logic                   o_bram_re,
   output logic [ADDR_WIDTH-1:0]  o_bram_ra,
   input  logic [DATA_WIDTH-1:0]  i_bram_rd
);

   localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH+1)'(SEG_DEPTH);

   logic                                  wr_acc;
   logic [NUM_STREAMS-1:0]                elig;
   logic [NUM_STREAMS-1:0]                gnt;
   logic [SID_WIDTH-1:0]                  gnt_idx;
   logic [NUM_STREAMS-1:0][PTR_WIDTH-1:0] wptr_all;
   logic [NUM_STREAMS-1:0][PTR_WIDTH-1:0] rptr_all;

   logic [BRAM_LATENCY-1:0]                rv_q, rv_d;
   logic [BRAM_LATENCY-1:0][SID_WIDTH-1:0] rsid_q, rsid_d;

   // No full bypass: a grant in the same cycle never frees room for this write.
   assign o_wr_r = !o_full[i_wr_sid];
   assign wr_acc = i_wr_v && o_wr_r && !reset;

   // Registered empty mask keeps a fresh write unreadable until next cycle,
   // so read and write addresses can never collide.
   assign elig = i_rd_req & ~o_empty & {NUM_STREAMS{!reset}};

   rr_arbiter #(
      .N  (NUM_STREAMS),
      .IW (SID_WIDTH)
   ) u_arb (
      .clk2x (clk2x),
      .reset (reset),
      .req_i (elig),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   assign o_rd_gnt  = gnt;
   assign o_bram_we = wr_acc;
   assign o_bram_wd = i_wr_d;
   assign o_bram_wa = ADDR_WIDTH'(pack_addr(32'(i_wr_sid), 32'(wptr_all[i_wr_sid]), PTR_WIDTH));
   assign o_bram_re = |gnt;
   assign o_bram_ra = ADDR_WIDTH'(pack_addr(32'(gnt_idx), 32'(rptr_all[gnt_idx]), PTR_WIDTH));

   for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_queue
      logic                 inc, dec;
      logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
      logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
      logic [PTR_WIDTH:0]   cnt_q, cnt_d;
      logic                 empty_q, full_q;

      assign inc = wr_acc && (i_wr_sid == SID_WIDTH'(s));
      assign dec = gnt[s];

      always_comb begin
         wptr_d = wptr_q;
         rptr_d = rptr_q;
         cnt_d  = cnt_q;
         if (inc) begin
            wptr_d = wptr_q + PTR_WIDTH'(1);
         end
         if (dec) begin
            rptr_d = rptr_q + PTR_WIDTH'(1);
         end
         if (inc && !dec) begin
            cnt_d = cnt_q + (PTR_WIDTH+1)'(1);
         end else if (dec && !inc) begin
            cnt_d = cnt_q - (PTR_WIDTH+1)'(1);
         end
      end

      always_ff @(posedge clk2x) begin
         if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
         end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CNT_FULL);
         end
      end

      assign wptr_all[s] = wptr_q;
      assign rptr_all[s] = rptr_q;
      assign o_empty[s]  = empty_q;
      assign o_full[s]   = full_q;
   end

   // Valid/sid ride alongside the BRAM read so they line up with i_bram_rd.
   always_comb begin
      rv_d      = rv_q;
      rsid_d    = rsid_q;
      rv_d[0]   = |gnt;
      rsid_d[0] = gnt_idx;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
         rv_d[i]   = rv_q[i-1];
         rsid_d[i] = rsid_q[i-1];
      end
   end

   always_ff @(posedge clk2x) begin
      if (reset) begin
         rv_q   <= '0;
         rsid_q <= '0;
      end else begin
         rv_q   <= rv_d;
         rsid_q <= rsid_d;
      end
   end

   assign o_rd_v   = rv_q[BRAM_LATENCY-1];
   assign o_rd_sid = rsid_q[BRAM_LATENCY-1];
   assign o_rd_d   = i_bram_rd;

endmodule

// File: tb/tb_bram_stream_sched.sv
// Self-checking bench for bram_stream_sched with a behavioural BRAM and a
// queue-based reference model of the per-stream FIFOs and round-robin reads.
module tb_bram_stream_sched;
   import msb_pkg::*;

   localparam int NS  = 4;
   localparam int DW  = 64;
   localparam int SEG = 128;

   logic          clk2x;
   logic          reset;
   logic          i_wr_v;
   logic [1:0]    i_wr_sid;
   logic [DW-1:0] i_wr_d;
   logic          o_wr_r;
   logic [NS-1:0] i_rd_req;
   logic [NS-1:0] o_rd_gnt;
   logic          o_rd_v;
   logic [1:0]    o_rd_sid;
   logic [DW-1:0] o_rd_d;
   logic [NS-1:0] o_empty;
   logic [NS-1:0] o_full;
   logic          o_bram_we;
   logic [8:0]    o_bram_wa;
   logic [DW-1:0] o_bram_wd;
   logic          o_bram_re;
   logic [8:0]    o_bram_ra;
   logic [DW-1:0] i_bram_rd;

   bram_stream_sched dut (
      .clk2x     (clk2x),
      .reset     (reset),
      .i_wr_v    (i_wr_v),
      .i_wr_sid  (i_wr_sid),
      .i_wr_d    (i_wr_d),
      .o_wr_r    (o_wr_r),
      .i_rd_req  (i_rd_req),
      .o_rd_gnt  (o_rd_gnt),
      .o_rd_v    (o_rd_v),
      .o_rd_sid  (o_rd_sid),
      .o_rd_d    (o_rd_d),
      .o_empty   (o_empty),
      .o_full    (o_full),
      .o_bram_we (o_bram_we),
      .o_bram_wa (o_bram_wa),
      .o_bram_wd (o_bram_wd),
      .o_bram_re (o_bram_re),
      .o_bram_ra (o_bram_ra),
      .i_bram_rd (i_bram_rd)
   );

   initial clk2x = 1'b0;
   always #5 clk2x = ~clk2x;

   // Behavioural BRAM with two-cycle read latency.
   logic [DW-1:0] mem [512];
   logic [8:0]    bram_ra_q;
   logic [DW-1:0] bram_rd_q;
   always @(posedge clk2x) begin
      if (o_bram_we) mem[o_bram_wa] <= o_bram_wd;
      bram_ra_q <= o_bram_ra;
      bram_rd_q <= mem[bram_ra_q];
   end
   assign i_bram_rd = bram_rd_q;

   // Reference model: one data queue per stream plus pointers and rr position.
   logic [DW-1:0] mq [NS][$];
   int            m_wp [NS];
   int            m_rp [NS];
   int            m_rr;
   bit            ret_v   [2];
   int            ret_sid [2];
   logic [DW-1:0] ret_d   [2];

   bit            e_wr_r, e_we;
   int            e_g;
   logic [NS-1:0] e_gnt, e_empty, e_full;
   logic [8:0]    e_wa, e_ra;

   int passed = 0;
   int total  = 0;

   task automatic drive(input bit wv, input int sid, input logic [DW-1:0] d, input logic [NS-1:0] req);
      i_wr_v   = wv;
      i_wr_sid = 2'(sid);
      i_wr_d   = d;
      i_rd_req = req;
      e_wr_r   = (mq[sid].size() != SEG);
      e_we     = wv && e_wr_r && !reset;
      e_wa     = 9'(sid * SEG + m_wp[sid]);
      e_g      = -1;
      if (!reset) begin
         for (int i = 0; i < NS; i++) begin
            int g;
            g = (m_rr + i) % NS;
            if (e_g < 0 && req[g] && mq[g].size() != 0) e_g = g;
         end
      end
      e_gnt = (e_g >= 0) ? NS'(1 << e_g) : '0;
      e_ra  = (e_g >= 0) ? 9'(e_g * SEG + m_rp[e_g]) : 9'd0;
      for (int s = 0; s < NS; s++) begin
         e_empty[s] = (mq[s].size() == 0);
         e_full[s]  = (mq[s].size() == SEG);
      end
      #2;
   endtask

   task automatic tick();
      logic [DW-1:0] pd;
      pd = '0;
      if (e_g >= 0) begin
         pd        = mq[e_g].pop_front();
         m_rp[e_g] = (m_rp[e_g] + 1) % SEG;
         m_rr      = (e_g + 1) % NS;
      end
      if (e_we) begin
         mq[i_wr_sid].push_back(i_wr_d);
         m_wp[i_wr_sid] = (m_wp[i_wr_sid] + 1) % SEG;
      end
      ret_v[1]   = ret_v[0];
      ret_sid[1] = ret_sid[0];
      ret_d[1]   = ret_d[0];
      ret_v[0]   = (e_g >= 0);
      ret_sid[0] = (e_g >= 0) ? e_g : 0;
      ret_d[0]   = pd;
      if (reset) begin
         for (int s = 0; s < NS; s++) begin
            mq[s].delete();
            m_wp[s] = 0;
            m_rp[s] = 0;
         end
         m_rr     = 0;
         ret_v[0] = 0;
         ret_v[1] = 0;
      end
      @(posedge clk2x);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, '0, '0);
         tick();
      end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(0, 0, '0, '0);
      total++;
      if ({o_empty, o_full, o_rd_v, o_bram_we, o_bram_re} !== {4'hF, 4'h0, 3'b000})
         $display("FAIL reset_state: got empty=%b full=%b rd_v=%b we=%b re=%b, want empty=1111 full=0000 rd_v=0 we=0 re=0",
                  o_empty, o_full, o_rd_v, o_bram_we, o_bram_re);
      else passed++;
      total++;
      if (o_rd_sid !== 2'd0) $display("FAIL reset_rd_sid: got %0d want 0", o_rd_sid);
      else passed++;
      tick();
   endtask

   task automatic test_single_stream();
      logic [DW-1:0] base;
      base = 64'hA0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 2, base + DW'(i), '0);
         total++;
         if ({o_bram_we, o_bram_wa} !== {1'b1, 9'(256 + i)})
            $display("FAIL single_wr[%0d]: got we=%b wa=%0d want we=1 wa=%0d", i, o_bram_we, o_bram_wa, 256 + i);
         else passed++;
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, '0, (i < 4) ? 4'b0100 : 4'b0000);
         if (i < 4) begin
            total++;
            if ({o_rd_gnt, o_bram_re, o_bram_ra} !== {4'b0100, 1'b1, 9'(256 + i)})
               $display("FAIL single_rd_addr[%0d]: got gnt=%b re=%b ra=%0d want gnt=0100 re=1 ra=%0d",
                        i, o_rd_gnt, o_bram_re, o_bram_ra, 256 + i);
            else passed++;
         end
         if (i >= 2) begin
            total++;
            if ({o_rd_v, o_rd_sid, o_rd_d} !== {1'b1, 2'd2, base + DW'(i - 2)})
               $display("FAIL single_rd_data[%0d]: got v=%b sid=%0d d=%h want v=1 sid=2 d=%h",
                        i - 2, o_rd_v, o_rd_sid, o_rd_d, base + DW'(i - 2));
            else passed++;
         end
         tick();
      end
      drive(0, 0, '0, '0);
      total++;
      if ({o_empty[2], o_rd_v} !== 2'b10)
         $display("FAIL single_drained: got empty2=%b rd_v=%b want empty2=1 rd_v=0", o_empty[2], o_rd_v);
      else passed++;
      tick();
   endtask

   task automatic test_fill_wrap();
      int refused;
      refused = 0;
      do_reset();
      for (int i = 0; i < SEG; i++) begin
         drive(1, 1, DW'(i), '0);
         if (!o_wr_r) refused++;
         tick();
      end
      total++;
      if (refused !== 0) $display("FAIL fill_accept: got %0d refusals want 0", refused);
      else passed++;
      drive(1, 1, 64'hDEAD, '0);
      total++;
      if ({o_full[1], o_wr_r, o_bram_we} !== 3'b100)
         $display("FAIL fill_full: got full1=%b wr_r=%b we=%b want full1=1 wr_r=0 we=0", o_full[1], o_wr_r, o_bram_we);
      else passed++;
      tick();
      drive(1, 1, 64'hDEAD, 4'b0010);
      total++;
      if ({o_wr_r, o_bram_we, o_rd_gnt, o_bram_ra} !== {2'b00, 4'b0010, 9'd128})
         $display("FAIL full_no_bypass: got wr_r=%b we=%b gnt=%b ra=%0d want wr_r=0 we=0 gnt=0010 ra=128",
                  o_wr_r, o_bram_we, o_rd_gnt, o_bram_ra);
      else passed++;
      tick();
      drive(1, 1, 64'hBEEF, '0);
      total++;
      if ({o_wr_r, o_bram_we, o_bram_wa} !== {2'b11, 9'd128})
         $display("FAIL wrap_write: got wr_r=%b we=%b wa=%0d want wr_r=1 we=1 wa=128", o_wr_r, o_bram_we, o_bram_wa);
      else passed++;
      tick();
      drive(1, 1, 64'h1234, '0);
      total++;
      if ({o_full[1], o_wr_r, o_rd_v, o_rd_sid, o_rd_d} !== {3'b101, 2'd1, 64'h0})
         $display("FAIL refill_full: got full1=%b wr_r=%b rd_v=%b sid=%0d d=%h want full1=1 wr_r=0 rd_v=1 sid=1 d=0",
                  o_full[1], o_wr_r, o_rd_v, o_rd_sid, o_rd_d);
      else passed++;
      tick();
   endtask

   task automatic test_fairness();
      do_reset();
      for (int s = 0; s < NS; s++) begin
         for (int k = 0; k < 2; k++) begin
            drive(1, s, DW'(s * 16 + k), '0);
            tick();
         end
      end
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, '0, 4'hF);
         total++;
         if (o_rd_gnt !== 4'(1 << (i % NS)))
            $display("FAIL fair_rotate[%0d]: got gnt=%b want %b", i, o_rd_gnt, 4'(1 << (i % NS)));
         else passed++;
         tick();
      end
   endtask

   task automatic test_same_cycle();
      int n;
      n = 0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, DW'(k), '0);
         tick();
      end
      drive(1, 0, 64'h55, 4'b0001);
      total++;
      if ({o_rd_gnt, o_bram_we, o_bram_wa} !== {4'b0001, 1'b1, 9'd5})
         $display("FAIL same_cycle_wr_rd: got gnt=%b we=%b wa=%0d want gnt=0001 we=1 wa=5", o_rd_gnt, o_bram_we, o_bram_wa);
      else passed++;
      tick();
      for (int k = 0; k < 10; k++) begin
         drive(0, 0, '0, 4'b0001);
         if (o_rd_gnt[0]) n++;
         tick();
      end
      total++;
      if (n !== 5) $display("FAIL same_cycle_count: got %0d grants after drain want 5", n);
      else passed++;
      drive(1, 3, 64'h77, 4'b1000);
      total++;
      if ({o_rd_gnt, o_bram_re} !== 5'b00000)
         $display("FAIL empty_write_no_grant: got gnt=%b re=%b want gnt=0000 re=0", o_rd_gnt, o_bram_re);
      else passed++;
      tick();
      drive(0, 3, '0, 4'b1000);
      total++;
      if ({o_rd_gnt, o_bram_ra} !== {4'b1000, 9'd384})
         $display("FAIL empty_write_next_grant: got gnt=%b ra=%0d want gnt=1000 ra=384", o_rd_gnt, o_bram_ra);
      else passed++;
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, '0, '0);
         tick();
      end
   endtask

   task automatic test_reset_inflight();
      int seen;
      seen = 0;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         drive(1, 1, DW'(k + 9), '0);
         tick();
      end
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, '0, 4'b0010);
         tick();
      end
      reset = 1'b1;
      drive(0, 0, '0, '0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         drive(0, 0, '0, '0);
         if (o_rd_v) seen++;
         tick();
      end
      total++;
      if (seen !== 0) $display("FAIL reset_inflight: got %0d valid cycles after reset want 0", seen);
      else passed++;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1600; c++) begin
         bit            wv;
         int            sid;
         logic [NS-1:0] req;
         if (c < 800) begin
            wv  = ($urandom_range(0, 3) != 0);
            sid = ($urandom_range(0, 1) != 0) ? 1 : int'($urandom_range(0, 3));
            req = 4'($urandom) & 4'($urandom) & 4'($urandom);
         end else begin
            wv  = ($urandom_range(0, 3) == 0);
            sid = int'($urandom_range(0, 3));
            req = 4'($urandom);
         end
         drive(wv, sid, {$urandom, $urandom}, req);
         total++;
         if ({o_wr_r, o_rd_gnt, o_bram_we, o_bram_re, o_empty, o_full, o_rd_v} !==
             {e_wr_r, e_gnt, e_we, (e_g >= 0), e_empty, e_full, ret_v[1]})
            $display("FAIL rand_ctl[%0d]: got wr_r=%b gnt=%b we=%b re=%b empty=%b full=%b v=%b want wr_r=%b gnt=%b we=%b re=%b empty=%b full=%b v=%b",
                     c, o_wr_r, o_rd_gnt, o_bram_we, o_bram_re, o_empty, o_full, o_rd_v,
                     e_wr_r, e_gnt, e_we, (e_g >= 0), e_empty, e_full, ret_v[1]);
         else passed++;
         if (e_we) begin
            total++;
            if (o_bram_wa !== e_wa) $display("FAIL rand_wa[%0d]: got %0d want %0d", c, o_bram_wa, e_wa);
            else passed++;
         end
         if (e_g >= 0) begin
            total++;
            if (o_bram_ra !== e_ra) $display("FAIL rand_ra[%0d]: got %0d want %0d", c, o_bram_ra, e_ra);
            else passed++;
         end
         if (ret_v[1]) begin
            total++;
            if ({o_rd_sid, o_rd_d} !== {2'(ret_sid[1]), ret_d[1]})
               $display("FAIL rand_rdata[%0d]: got sid=%0d d=%h want sid=%0d d=%h", c, o_rd_sid, o_rd_d, ret_sid[1], ret_d[1]);
            else passed++;
         end
         tick();
      end
   endtask

   initial begin
      reset    = 1'b1;
      i_wr_v   = 1'b0;
      i_wr_sid = '0;
      i_wr_d   = '0;
      i_rd_req = '0;
      m_rr     = 0;
      for (int i = 0; i < 2; i++) begin
         ret_v[i]   = 0;
         ret_sid[i] = 0;
         ret_d[i]   = '0;
      end
      test_reset();
      test_single_stream();
      test_fill_wrap();
      test_fairness();
      test_same_cycle();
      test_reset_inflight();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
